// File: rtl/hs_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs_ram_arbiter
// Brief    : Shares the core's single-port work RAM between CPU and hiscore engine
// Revision : 1.0  initial release
// ============================================================================
module hs_ram_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 8,
    parameter int RD_LAT       = 1,
    parameter int DRAIN_CYC    = 2,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cpu_ce,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_hold,
    input  logic          hs_access,
    input  logic          hs_strobe,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_wdata,
    output logic [DW-1:0] hs_rdata,
    output logic          hs_ack,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic          owner,
    output logic          timeout_err
);

    localparam int              c_CW      = 10;
    localparam logic [2:0]      c_IDLE    = 3'd0;
    localparam logic [2:0]      c_DRAIN   = 3'd1;
    localparam logic [2:0]      c_GRANT   = 3'd2;
    localparam logic [2:0]      c_ACCESS  = 3'd3;
    localparam logic [2:0]      c_ACK     = 3'd4;
    localparam logic [2:0]      c_RELEASE = 3'd5;
    localparam logic [c_CW-1:0] c_DRAIN_N = c_CW'(DRAIN_CYC);
    localparam logic [c_CW-1:0] c_RD_N    = c_CW'(RD_LAT);
    localparam logic [c_CW-1:0] c_TMO_N   = c_CW'(IDLE_TIMEOUT);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);

    logic [2:0]      r_state, w_state_nxt;
    logic            r_owner, w_owner_nxt;
    logic            r_cpu_hold, w_hold_nxt;
    logic            r_timeout_err, w_tmo_nxt;
    logic            r_lockout, w_lock_nxt;
    logic            r_seen, w_seen_nxt;
    logic [c_CW-1:0] r_cnt, w_cnt_nxt;
    logic            r_we, w_we_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [DW-1:0]   r_wdata, w_wdata_nxt;
    logic [DW-1:0]   r_hs_rdata, w_rdata_nxt;
    logic            w_drain_done, w_idle_expire, w_rd_done;
    logic            w_hs_we, w_hs_ack;

    // r_cnt is shared: drain clocks in DRAIN, idle clocks in GRANT, read latency in ACCESS
    assign w_drain_done  = r_seen ? (r_cnt == c_DRAIN_N) : (cpu_ce && (c_DRAIN_N == '0));
    assign w_idle_expire = ((r_cnt + c_ONE) == c_TMO_N);
    assign w_rd_done     = (r_cnt == c_RD_N);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_owner       <= 1'b0;
            r_cpu_hold    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_lockout     <= 1'b0;
            r_seen        <= 1'b0;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_hs_rdata    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_owner       <= w_owner_nxt;
            r_cpu_hold    <= w_hold_nxt;
            r_timeout_err <= w_tmo_nxt;
            r_lockout     <= w_lock_nxt;
            r_seen        <= w_seen_nxt;
            r_cnt         <= w_cnt_nxt;
            r_we          <= w_we_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_hs_rdata    <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (hs_access && !r_lockout) w_state_nxt = c_DRAIN;
            c_DRAIN: begin
                if (!hs_access)        w_state_nxt = c_IDLE;
                else if (w_drain_done) w_state_nxt = c_GRANT;
            end
            c_GRANT: begin
                // a strobe beats a simultaneous session drop
                if (hs_strobe)          w_state_nxt = c_ACCESS;
                else if (!hs_access)    w_state_nxt = c_RELEASE;
                else if (w_idle_expire) w_state_nxt = c_RELEASE;
            end
            c_ACCESS:  if (r_we || w_rd_done) w_state_nxt = c_ACK;
            c_ACK:     w_state_nxt = hs_access ? c_GRANT : c_RELEASE;
            c_RELEASE: w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_cpu_hold;
        w_tmo_nxt   = 1'b0;
        w_lock_nxt  = r_lockout;
        w_seen_nxt  = r_seen;
        w_cnt_nxt   = r_cnt;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_hs_rdata;
        w_hs_we     = (r_state == c_ACCESS) && r_we;
        w_hs_ack    = (r_state == c_ACK);
        case (r_state)
            c_IDLE: begin
                if (!hs_access) begin
                    w_lock_nxt = 1'b0;
                end else if (!r_lockout) begin
                    w_hold_nxt = 1'b1;
                    w_seen_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                end
            end
            c_DRAIN: begin
                if (!hs_access) begin
                    w_hold_nxt = 1'b0;
                end else if (w_drain_done) begin
                    w_owner_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (r_seen) begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end else if (cpu_ce) begin
                    w_seen_nxt = 1'b1;
                    w_cnt_nxt  = c_ONE;
                end
            end
            c_GRANT: begin
                if (hs_strobe) begin
                    w_we_nxt    = hs_we;
                    w_addr_nxt  = hs_addr;
                    w_wdata_nxt = hs_wdata;
                    w_cnt_nxt   = '0;
                end else if (!hs_access) begin
                    w_owner_nxt = 1'b0;
                end else if (w_idle_expire) begin
                    w_owner_nxt = 1'b0;
                    w_tmo_nxt   = 1'b1;
                    w_lock_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            c_ACCESS: begin
                if (!r_we) begin
                    if (w_rd_done) w_rdata_nxt = ram_rdata;
                    else           w_cnt_nxt   = r_cnt + c_ONE;
                end
            end
            c_ACK: begin
                if (hs_access) w_cnt_nxt   = '0;
                else           w_owner_nxt = 1'b0;
            end
            // owner already dropped; hold stays one more clock so the bus settles
            c_RELEASE: w_hold_nxt = 1'b0;
            default: ;
        endcase
    end

    assign ram_addr    = r_owner ? r_addr  : cpu_addr;
    assign ram_wdata   = r_owner ? r_wdata : cpu_wdata;
    assign ram_we      = r_owner ? w_hs_we : cpu_we;
    assign cpu_rdata   = ram_rdata;
    assign cpu_hold    = r_cpu_hold;
    assign owner       = r_owner;
    assign hs_rdata    = r_hs_rdata;
    assign hs_ack      = w_hs_ack;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_hs_ram_arbiter.sv
`default_nettype none
// Bench for hs_ram_arbiter: random hiscore sessions checked against cycle rules and a shadow memory.
module tb_hs_ram_arbiter;
    localparam int AW           = 16;
    localparam int DW           = 8;
    localparam int RD_LAT       = 1;
    localparam int DRAIN_CYC    = 2;
    localparam int IDLE_TIMEOUT = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          cpu_ce, cpu_we, cpu_hold;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          hs_access, hs_strobe, hs_we, hs_ack;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata, hs_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          ram_we, owner, timeout_err;

    int            n_total = 0;
    int            n_bad   = 0;
    bit [DW-1:0]   mem    [0:65535];
    bit [DW-1:0]   shadow [0:65535];
    bit [DW-1:0]   rd_pipe [0:RD_LAT-1];
    logic [DW-1:0] last_rd = '0;
    logic [AW-1:0] pool [0:7];

    always #5 clk_sys = ~clk_sys;

    hs_ram_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .DRAIN_CYC(DRAIN_CYC), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_ce(cpu_ce), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .hs_access(hs_access), .hs_strobe(hs_strobe), .hs_we(hs_we), .hs_addr(hs_addr),
        .hs_wdata(hs_wdata), .hs_rdata(hs_rdata), .hs_ack(hs_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .owner(owner), .timeout_err(timeout_err)
    );

    // Single-port RAM with RD_LAT clocks of read latency
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        #1;
        check("cpu_ram_we", ram_we, 1);
        check("cpu_ram_addr", ram_addr, a);
        check("cpu_ram_wdata", ram_wdata, d);
        check("cpu_owner", owner, 0);
        check("cpu_hold_idle", cpu_hold, 0);
        tick();
        cpu_we = 1'b0;
        shadow[a] = d;
        tick();
        check("cpu_rdata", cpu_rdata, d);
    endtask

    // Raise the session, hold off cpu_ce for pre clocks, then expect grant DRAIN_CYC edges later
    task automatic do_grant(input int pre);
        hs_access = 1'b1;
        tick();
        check("drain_hold", cpu_hold, 1);
        check("drain_owner", owner, 0);
        for (int i = 0; i < pre; i++) begin
            hs_strobe = 1'($urandom_range(0, 1));
            tick();
            check("pre_owner", owner, 0);
            check("pre_no_ack", hs_ack, 0);
        end
        hs_strobe = 1'b0;
        cpu_ce = 1'b1;
        tick();
        cpu_ce = 1'b0;
        for (int k = 0; k <= DRAIN_CYC; k++) begin
            check("grant_owner", owner, (k == DRAIN_CYC));
            check("grant_hold", cpu_hold, 1);
            if (k < DRAIN_CYC) tick();
        end
    endtask

    // drop: 0 keep session, 1 drop with the strobe, 2 drop during the access
    task automatic do_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int drop);
        int n;
        int wes;
        hs_strobe = 1'b1; hs_we = we; hs_addr = a; hs_wdata = d;
        if (drop == 1) hs_access = 1'b0;
        tick();
        hs_strobe = 1'b0;
        hs_we = 1'($urandom); hs_addr = AW'($urandom); hs_wdata = DW'($urandom);
        if (drop == 2) hs_access = 1'b0;
        n = 1; wes = 0;
        while (!hs_ack && n < 20) begin
            if (ram_we) begin
                wes++;
                check("wr_addr", ram_addr, a);
                check("wr_data", ram_wdata, d);
                check("wr_cycle", n, 1);
            end
            if (!we) check("rd_addr", ram_addr, a);
            tick();
            n++;
        end
        check(we ? "wr_ack_lat" : "rd_ack_lat", n, we ? 2 : 2 + RD_LAT);
        check("we_pulses", wes, we);
        if (we) begin
            shadow[a] = d;
            check("rdata_hold", hs_rdata, last_rd);
        end else begin
            check("rd_data", hs_rdata, shadow[a]);
            last_rd = shadow[a];
        end
        tick();
        check("ack_pulse", hs_ack, 0);
        if (drop != 0) begin
            check("drop_owner", owner, 0);
            check("drop_hold_settle", cpu_hold, 1);
            tick();
            check("drop_hold", cpu_hold, 0);
        end else begin
            check("keep_owner", owner, 1);
        end
    endtask

    task automatic do_release(input logic [AW-1:0] a, input logic [DW-1:0] d);
        hs_access = 1'b0;
        tick();
        check("rel_owner", owner, 0);
        check("rel_hold_settle", cpu_hold, 1);
        tick();
        check("rel_hold", cpu_hold, 0);
        cpu_write(a, d);
    endtask

    task automatic do_abort();
        int m;
        hs_access = 1'b1;
        tick();
        check("abort_drain_hold", cpu_hold, 1);
        m = $urandom_range(0, DRAIN_CYC);
        cpu_ce = 1'b1;
        for (int i = 0; i <= m; i++) begin
            if (i == m) hs_access = 1'b0;
            tick();
            cpu_ce = 1'b0;
            check("abort_owner", owner, 0);
        end
        check("abort_hold", cpu_hold, 0);
        repeat (3) begin
            tick();
            check("abort_owner_after", owner, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=time_limit expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            nacc;
        int            drop;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        pool = '{16'h8800, 16'h8010, 16'h8801, 16'h0000, 16'hFFFF, 16'h1234, 16'h8802, 16'h4000};
        cpu_ce = 0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 0;
        hs_access = 0; hs_strobe = 0; hs_we = 0; hs_addr = '0; hs_wdata = '0;
        drop = 0;
        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_owner", owner, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_ack", hs_ack, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_rdata", hs_rdata, 0);
        check("rst_ram_we", ram_we, 0);
        reset_n = 1'b1;
        tick();

        // directed: idle CPU write, grant, write/read, release
        cpu_write(16'h8010, 8'h5A);
        do_grant(2);
        do_access(1'b1, 16'h8800, 8'hA5, 0);
        do_access(1'b0, 16'h8800, 8'h00, 0);
        check("rd_A5", hs_rdata, 8'hA5);
        do_release(16'h8011, 8'h3C);
        do_abort();

        // idle timeout followed by lockout until hs_access toggles
        do_grant(1);
        n = 0;
        while (!timeout_err && n < 50) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, IDLE_TIMEOUT);
        check("tmo_owner", owner, 0);
        tick();
        check("tmo_pulse", timeout_err, 0);
        check("tmo_hold", cpu_hold, 0);
        repeat (6) begin
            tick();
            check("lockout_hold", cpu_hold, 0);
            check("lockout_owner", owner, 0);
        end
        hs_access = 1'b0;
        tick();
        do_grant(0);
        do_release(16'h4000, 8'h77);

        // randomized sessions
        for (int s = 0; s < 30; s++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    do_grant($urandom_range(0, 3));
                    nacc = $urandom_range(1, 5);
                    for (int i = 0; i < nacc; i++) begin
                        we   = 1'($urandom_range(0, 1));
                        a    = pool[$urandom_range(0, 7)];
                        d    = DW'($urandom);
                        drop = (i == nacc - 1) ? int'($urandom_range(0, 2)) : 0;
                        do_access(we, a, d, drop);
                        if (drop == 0 && i < nacc - 1) repeat ($urandom_range(0, 3)) tick();
                    end
                    if (drop == 0) do_release(pool[$urandom_range(0, 7)], DW'($urandom));
                end
                2: do_abort();
                default: cpu_write(pool[$urandom_range(0, 7)], DW'($urandom));
            endcase
        end

        // asynchronous reset in the middle of a read access
        do_grant(0);
        hs_strobe = 1'b1; hs_we = 1'b0; hs_addr = 16'h8800;
        tick();
        hs_strobe = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_owner", owner, 0);
        check("arst_hold", cpu_hold, 0);
        check("arst_ack", hs_ack, 0);
        check("arst_tmo", timeout_err, 0);
        check("arst_rdata", hs_rdata, 0);
        check("arst_ram_we", ram_we, 0);
        hs_access = 1'b0;
        tick();
        check("arst_no_ack", hs_ack, 0);
        reset_n = 1'b1;
        tick();
        check("arst_owner_after", owner, 0);
        check("arst_hold_after", cpu_hold, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game core's single-port work RAM between the CPU and the hiscore save/restore engine.
- On a hiscore session request it pauses the CPU, waits for the in-flight bus cycle to drain, then hands the RAM port to the hiscore engine for individual read/write accesses.
- Returns ownership to the CPU on session end or on an idle timeout.
- Sits between the hiscore module, the pause logic and the core RAM, in the clk_sys domain.

Parameters:
- AW, 16, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, RAM read latency in clocks (1..3).
- DRAIN_CYC, 2, extra clocks after the first cpu_ce before grant (0..15).
- IDLE_TIMEOUT, 255, clocks in GRANT without hs_strobe before forced release (1..1023).

Ports:
- clk_sys, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- cpu_ce, in, 1, strobe marking completion of a CPU bus cycle.
- cpu_addr, in, AW, CPU address.
- cpu_wdata, in, DW, CPU write data.
- cpu_we, in, 1, CPU write enable.
- cpu_rdata, out, DW, RAM read data to the CPU.
- cpu_hold, out, 1, CPU pause request.
- hs_access, in, 1, hiscore session request (level).
- hs_strobe, in, 1, single access request (pulse).
- hs_we, in, 1, access is a write.
- hs_addr, in, AW, hiscore address.
- hs_wdata, in, DW, hiscore write data.
- hs_rdata, out, DW, registered read data.
- hs_ack, out, 1, one-clock access-complete pulse.
- ram_addr, out, AW, RAM address.
- ram_wdata, out, DW, RAM write data.
- ram_we, out, 1, RAM write enable.
- ram_rdata, in, DW, RAM read data.
- owner, out, 1, 0 = CPU, 1 = hiscore.
- timeout_err, out, 1, one-clock pulse on forced release.

Behaviour:
- Reset (async, reset_n low):
  - state IDLE; owner, cpu_hold, hs_ack, timeout_err = 0; hs_rdata = 0; counters cleared.
  - Reset asserted mid-session drops cpu_hold and returns ownership to the CPU immediately.
- RAM mux:
  - owner = 0: ram_addr/ram_wdata/ram_we = cpu_addr/cpu_wdata/cpu_we, combinational.
  - owner = 1: ram_addr/ram_wdata come from the latched hiscore registers; ram_we is driven by the FSM only.
  - cpu_rdata = ram_rdata at all times.
- States:
  - IDLE: if hs_access = 1, set cpu_hold <= 1 and go to DRAIN.
  - DRAIN: wait for the first cpu_ce with cpu_hold high, then count DRAIN_CYC clocks. At expiry set owner <= 1 and go to GRANT. If hs_access falls, set cpu_hold <= 0 and go to IDLE; owner never becomes 1.
  - GRANT:
    - hs_strobe: latch hs_we/hs_addr/hs_wdata, clear the idle counter, go to ACCESS.
    - hs_access = 0 with no strobe: go to RELEASE.
    - Idle counter reaches IDLE_TIMEOUT: pulse timeout_err, go to RELEASE, and set a lockout flag.
  - ACCESS:
    - Write: ram_we = 1 for exactly one clock, the clock after the strobe.
    - Read: the address is presented from the clock after the strobe; ram_rdata is sampled RD_LAT clocks later into hs_rdata.
    - Then go to ACK.
  - ACK: hs_ack = 1 for one clock. Go to GRANT if hs_access = 1, else RELEASE.
  - RELEASE: owner <= 0 this clock, cpu_hold <= 0 the following clock (one-clock bus settle), then IDLE.
  - Lockout: IDLE ignores hs_access until it has been observed low, then clears the lockout.
- Latency:
  - Strobe in cycle T. Write: ram_we in T+1, hs_ack in T+2. Read: hs_rdata valid and hs_ack in T+2+RD_LAT; hs_rdata then holds until the next read.
- hs_strobe outside GRANT is ignored, with no ack.
- hs_access dropping during ACCESS does not abort; the access completes and its ack is issued.
- Simultaneous hs_strobe and hs_access fall in GRANT: the strobe wins, the access completes, then release.
- cpu_ce in the same clock as the DRAIN entry counts as the first cpu_ce.

Test Plan:
- Reset idle: CPU write of 0x5A to 0x8010 → ram_we = 1, ram_addr = 0x8010, owner = 0, cpu_hold = 0.
- Grant: hs_access high, cpu_ce three clocks later, DRAIN_CYC = 2 → owner = 1 exactly two clocks after that cpu_ce; cpu_hold high throughout.
- Write then read: write 0xA5 to 0x8800, then read 0x8800 with RD_LAT = 1 → ram_we asserted one clock only; hs_ack at T+2 and T+3; hs_rdata = 0xA5.
- Release: hs_access drops in GRANT → owner = 0 next clock, cpu_hold = 0 one clock later; a following CPU access reaches the RAM.
- Abort and timeout: hs_access dropped in DRAIN → owner never 1. With IDLE_TIMEOUT = 8 and hs_access held without strobe → timeout_err pulse after 8 clocks; no re-grant until hs_access toggles low then high.
- Async reset during ACCESS → all outputs 0 immediately, no hs_ack.
